// File: rtl/move_stack_lifo.sv
`default_nettype none
// ============================================================================
// Module      : move_stack_lifo
// Description : Circular-buffer LIFO of ant move codes used for backtracking.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module move_stack_lifo #(
    parameter int WIDTH     = 3,
    parameter int DEPTH     = 32,
    parameter bit OVERWRITE = 1'b1,
    parameter int CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int            c_PW    = $clog2(DEPTH);
    localparam logic [c_PW-1:0] c_LAST = c_PW'(DEPTH - 1);
    localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_head;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_pop_data;
    logic             r_pop_valid;
    logic             r_overflow;
    logic             r_underflow;

    logic [c_PW-1:0]  w_top_idx;
    logic [c_PW-1:0]  w_head_inc;
    logic [WIDTH-1:0] w_top_data;
    logic             w_empty;
    logic             w_full;
    logic [c_PW-1:0]  w_head_nxt;
    logic [CW-1:0]    w_count_nxt;
    logic             w_mem_we;
    logic [c_PW-1:0]  w_mem_addr;
    logic             w_do_pop;
    logic             w_ovf;
    logic             w_unf;

    // Explicit wrap so non-power-of-two depths index correctly.
    assign w_top_idx  = (r_head == '0)     ? c_LAST : r_head - 1'b1;
    assign w_head_inc = (r_head == c_LAST) ? '0     : r_head + 1'b1;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_DEPTH);
    assign w_top_data = w_empty ? '0 : r_mem[w_top_idx];

    always_comb begin
        w_head_nxt  = r_head;
        w_count_nxt = r_count;
        w_mem_we    = 1'b0;
        w_mem_addr  = r_head;
        w_do_pop    = 1'b0;
        w_ovf       = 1'b0;
        w_unf       = 1'b0;
        if (clear) begin
            w_count_nxt = '0;
        end else if (push && pop && !w_empty) begin
            // Replace top: pointer and occupancy are untouched.
            w_mem_we   = 1'b1;
            w_mem_addr = w_top_idx;
            w_do_pop   = 1'b1;
        end else if (push) begin
            if (!w_full) begin
                w_mem_we    = 1'b1;
                w_head_nxt  = w_head_inc;
                w_count_nxt = r_count + 1'b1;
            end else begin
                w_ovf = 1'b1;
                if (OVERWRITE) begin
                    w_mem_we   = 1'b1;
                    w_head_nxt = w_head_inc;
                end
            end
        end else if (pop) begin
            if (!w_empty) begin
                w_do_pop    = 1'b1;
                w_head_nxt  = w_top_idx;
                w_count_nxt = r_count - 1'b1;
            end else begin
                w_unf = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head      <= '0;
            r_count     <= '0;
            r_pop_data  <= '0;
            r_pop_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_head      <= w_head_nxt;
            r_count     <= w_count_nxt;
            r_pop_valid <= w_do_pop;
            r_overflow  <= w_ovf;
            r_underflow <= w_unf;
            if (w_do_pop) begin
                r_pop_data <= w_top_data;
            end
        end
    end

    assign top_data  = w_top_data;
    assign pop_data  = r_pop_data;
    assign pop_valid = r_pop_valid;
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_move_stack_lifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_move_stack_lifo
// Description : Randomised bench for move_stack_lifo, both full-push policies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_move_stack_lifo;

    logic clk;
    logic rst_n;
    logic clear;
    logic push;
    logic pop;
    logic [2:0] push_data;

    logic [1:0][2:0] top_d;
    logic [1:0][2:0] pop_d;
    logic [1:0][2:0] cnt_o;
    logic [1:0]      pv_o;
    logic [1:0]      emp_o;
    logic [1:0]      full_o;
    logic [1:0]      ovf_o;
    logic [1:0]      unf_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: st[k][0] is the bottom, st[k][n[k]-1] the top.
    int st [2][4];
    int n [2];
    int exp_pd [2];
    int exp_pv [2];
    int exp_ovf [2];
    int exp_unf [2];

    // Instance 0 discards the oldest entry when full, instance 1 rejects.
    move_stack_lifo #(.WIDTH(3), .DEPTH(4), .OVERWRITE(1'b1)) u_dut_ow (
        .clk(clk), .rst_n(rst_n), .clear(clear), .push(push), .pop(pop),
        .push_data(push_data), .top_data(top_d[0]), .pop_data(pop_d[0]),
        .pop_valid(pv_o[0]), .count(cnt_o[0]), .empty(emp_o[0]), .full(full_o[0]),
        .overflow(ovf_o[0]), .underflow(unf_o[0])
    );

    move_stack_lifo #(.WIDTH(3), .DEPTH(4), .OVERWRITE(1'b0)) u_dut_rj (
        .clk(clk), .rst_n(rst_n), .clear(clear), .push(push), .pop(pop),
        .push_data(push_data), .top_data(top_d[1]), .pop_data(pop_d[1]),
        .pop_valid(pv_o[1]), .count(cnt_o[1]), .empty(emp_o[1]), .full(full_o[1]),
        .overflow(ovf_o[1]), .underflow(unf_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            n[k] = 0; exp_pd[k] = 0; exp_pv[k] = 0; exp_ovf[k] = 0; exp_unf[k] = 0;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("count[%0d]", k), cnt_o[k], n[k]);
            check($sformatf("empty[%0d]", k), emp_o[k], (n[k] == 0) ? 1 : 0);
            check($sformatf("full[%0d]", k), full_o[k], (n[k] == 4) ? 1 : 0);
            check($sformatf("top[%0d]", k), top_d[k], (n[k] == 0) ? 0 : st[k][n[k]-1]);
            check($sformatf("pop_valid[%0d]", k), pv_o[k], exp_pv[k]);
            check($sformatf("pop_data[%0d]", k), pop_d[k], exp_pd[k]);
            check($sformatf("overflow[%0d]", k), ovf_o[k], exp_ovf[k]);
            check($sformatf("underflow[%0d]", k), unf_o[k], exp_unf[k]);
        end
    endtask

    // One clock cycle of stimulus; model advanced from pre-edge state.
    task automatic step(input bit c, input bit pu, input bit po, input int d);
        clear = c; push = pu; pop = po; push_data = 3'(d);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            exp_pv[k] = 0; exp_ovf[k] = 0; exp_unf[k] = 0;
            if (c) begin
                n[k] = 0;
            end else if (pu && po && n[k] > 0) begin
                exp_pd[k] = st[k][n[k]-1];
                exp_pv[k] = 1;
                st[k][n[k]-1] = d;
            end else if (pu) begin
                if (n[k] < 4) begin
                    st[k][n[k]] = d;
                    n[k]++;
                end else begin
                    exp_ovf[k] = 1;
                    if (k == 0) begin
                        for (int i = 0; i < 3; i++) st[k][i] = st[k][i+1];
                        st[k][3] = d;
                    end
                end
            end else if (po) begin
                if (n[k] > 0) begin
                    exp_pd[k] = st[k][n[k]-1];
                    exp_pv[k] = 1;
                    n[k]--;
                end else begin
                    exp_unf[k] = 1;
                end
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        check_all();
        rst_n = 1'b1;

        // LIFO order
        for (int i = 1; i <= 3; i++) step(0, 1, 0, i);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        // Overfill: discard-oldest vs reject, with head wrap
        for (int i = 1; i <= 5; i++) step(0, 1, 0, i);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        // Replace top, then replace on empty
        step(0, 1, 0, 6);
        step(0, 1, 0, 7);
        step(0, 1, 1, 2);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 1, 1, 5);
        // Underflow, then clear beats push
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        for (int i = 1; i <= 3; i++) step(0, 1, 0, i);
        step(1, 1, 0, 4);
        step(0, 0, 1, 0);
        // Full then replace: no overflow
        for (int i = 1; i <= 4; i++) step(0, 1, 0, i);
        step(0, 1, 1, 6);

        // Asynchronous reset between edges
        step(1, 0, 0, 0);
        step(0, 1, 0, 3);
        step(0, 1, 0, 5);
        clear = 1'b0; push = 1'b0; pop = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        #2;
        rst_n = 1'b1;
        step(0, 1, 0, 6);

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 9) < 5),
                 int'($urandom_range(0, 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
